// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART motor-command frame parser.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_W             = 5;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_e;

  // Index width that stays legal when only one payload byte is allowed.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-strobe input and command/error outputs of the frame parser.
interface uart_cmd_parser_if
  import uart_cmd_pkg::*;
#(
  parameter int MAX_PAYLOAD = 8
);

  logic                     i_Rx_DV;
  logic [7:0]               i_Rx_Byte;
  logic                     o_Cmd_Valid;
  logic [7:0]               o_Cmd_Id;
  logic [LEN_W-1:0]         o_Cmd_Len;
  logic [8*MAX_PAYLOAD-1:0] o_Cmd_Payload;
  logic                     o_Chk_Err;
  logic                     o_Len_Err;
  logic                     o_Timeout_Err;

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Cmd_Valid, o_Cmd_Id, o_Cmd_Len, o_Cmd_Payload,
    input  o_Chk_Err, o_Len_Err, o_Timeout_Err
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Cmd_Valid, o_Cmd_Id, o_Cmd_Len, o_Cmd_Payload,
    output o_Chk_Err, o_Len_Err, o_Timeout_Err
  );

endinterface

// File: rtl/uart_gap_timer.sv
// Mid-frame inter-byte gap counter; expire_o fires on the last allowed idle clock
// unless a byte arrives in that same cycle.
module uart_gap_timer #(
  parameter int TIMEOUT_CLKS = 3200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int               CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || !enable_i || expire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from UART byte strobes and publishes
// good commands as a held, registered word plus a one-cycle valid strobe.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         MAX_PAYLOAD  = 8,
  parameter int         TIMEOUT_CLKS = 3200,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  uart_cmd_parser_if.slave bus
);

  localparam int IDX_W = idx_width(MAX_PAYLOAD);

  state_e                        state_q;
  logic [7:0]                    cmd_q, sum_q, cmd_id_q;
  logic [LEN_W-1:0]              len_q, cmd_len_q;
  logic [IDX_W-1:0]              idx_q;
  logic [MAX_PAYLOAD-1:0][7:0]   shadow_q, payload_q, payload_d;
  logic                          valid_q, chk_err_q, len_err_q, timeout_err_q;
  logic                          gap_expire;

  uart_gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap_timer (
    .clk_i    (i_Clock),
    .rst_i    (i_Reset),
    .clear_i  (bus.i_Rx_DV),
    .enable_i (state_q != S_HUNT),
    .expire_o (gap_expire)
  );

  // Bytes beyond LEN may hold data from an earlier, longer frame; publish them as zero.
  always_comb begin
    payload_d = '0;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (k < int'(len_q)) payload_d[k] = shadow_q[k];
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      // NOTE: the shadow buffer is reset along with the control state, so no stale
      // frame data survives a reset.
      state_q       <= S_HUNT;
      cmd_q         <= '0;
      sum_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      cmd_id_q      <= '0;
      cmd_len_q     <= '0;
      payload_q     <= '0;
      valid_q       <= 1'b0;
      chk_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: every pulse defaults low and only the firing branch raises one, so the
      // strobes are single-cycle and mutually exclusive by construction.
      valid_q       <= 1'b0;
      chk_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      if (bus.i_Rx_DV) begin
        unique case (state_q)
          S_HUNT: begin
            if (bus.i_Rx_Byte == SYNC_BYTE) begin
              sum_q   <= '0;
              idx_q   <= '0;
              state_q <= S_CMD;
            end
          end
          S_CMD: begin
            cmd_q   <= bus.i_Rx_Byte;
            sum_q   <= bus.i_Rx_Byte;
            state_q <= S_LEN;
          end
          S_LEN: begin
            if (bus.i_Rx_Byte > 8'(MAX_PAYLOAD)) begin
              len_err_q <= 1'b1;
              state_q   <= S_HUNT;
            end else begin
              len_q   <= bus.i_Rx_Byte[LEN_W-1:0];
              sum_q   <= sum_q + bus.i_Rx_Byte;
              state_q <= (bus.i_Rx_Byte == 8'd0) ? S_CHK : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            shadow_q[idx_q] <= bus.i_Rx_Byte;
            sum_q           <= sum_q + bus.i_Rx_Byte;
            idx_q           <= idx_q + 1'b1;
            if (LEN_W'(idx_q) == len_q - 1'b1) state_q <= S_CHK;
          end
          S_CHK: begin
            if (bus.i_Rx_Byte == sum_q) begin
              valid_q   <= 1'b1;
              cmd_id_q  <= cmd_q;
              cmd_len_q <= len_q;
              payload_q <= payload_d;
            end else begin
              chk_err_q <= 1'b1;
            end
            state_q <= S_HUNT;
          end
          default: state_q <= S_HUNT;
        endcase
      end else if (gap_expire) begin
        timeout_err_q <= 1'b1;
        state_q       <= S_HUNT;
      end
    end
  end

  assign bus.o_Cmd_Valid   = valid_q;
  assign bus.o_Cmd_Id      = cmd_id_q;
  assign bus.o_Cmd_Len     = cmd_len_q;
  assign bus.o_Cmd_Payload = payload_q;
  assign bus.o_Chk_Err     = chk_err_q;
  assign bus.o_Len_Err     = len_err_q;
  assign bus.o_Timeout_Err = timeout_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench: byte streams are replayed through a frame-level reference
// model that predicts every strobe, its cycle, and the held command word.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int         MAX  = 8;
  localparam int         T    = 3200;
  localparam logic [7:0] SYNC = 8'hA5;

  localparam logic [1:0] K_VALID = 2'd0, K_CHK = 2'd1, K_LEN = 2'd2, K_TO = 2'd3;

  typedef struct packed {
    logic [1:0]       kind;
    logic [31:0]      at;
    logic [7:0]       id;
    logic [4:0]       len;
    logic [8*MAX-1:0] pay;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          multi = 0;

  logic [7:0]  stim_b[$];
  int unsigned stim_e[$];
  ev_t         exp_q[$];
  ev_t         obs_q[$];

  logic [7:0]       m_id;
  logic [4:0]       m_len;
  logic [8*MAX-1:0] m_pay;

  uart_cmd_parser_if #(.MAX_PAYLOAD(MAX)) bus ();

  uart_cmd_parser #(.MAX_PAYLOAD(MAX), .TIMEOUT_CLKS(T), .SYNC_BYTE(SYNC)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Record every strobe together with the command word visible in that cycle.
  always @(negedge clk) begin
    ev_t e;
    int  np;
    np = int'(bus.o_Cmd_Valid) + int'(bus.o_Chk_Err) + int'(bus.o_Len_Err) + int'(bus.o_Timeout_Err);
    if (np > 0) begin
      if (np > 1) multi++;
      e.kind = bus.o_Cmd_Valid ? K_VALID : bus.o_Chk_Err ? K_CHK : bus.o_Len_Err ? K_LEN : K_TO;
      e.at   = cyc;
      e.id   = bus.o_Cmd_Id;
      e.len  = bus.o_Cmd_Len;
      e.pay  = bus.o_Cmd_Payload;
      obs_q.push_back(e);
    end
  end

  function automatic string fmt(input ev_t e);
    return $sformatf("kind=%0d at=%0d id=%h len=%0d pay=%h", e.kind, e.at, e.id, e.len, e.pay);
  endfunction

  function automatic int rgap(input int mx);
    int r;
    r = int'($urandom_range(0, 59));
    if (mx > 1 && r == 0) return T;
    if (mx > 1 && r == 1) return T + 1;
    return int'($urandom_range(1, mx));
  endfunction

  // gap = number of clock edges since the previous strobe (1 = back-to-back).
  task automatic send_byte(input logic [7:0] v, input int gap);
    repeat (gap) @(negedge clk) begin
      bus.i_Rx_DV   = 1'b0;
      bus.i_Rx_Byte = 8'($urandom);
    end
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = v;
    stim_b.push_back(v);
    stim_e.push_back(cyc + 1);
  endtask

  task automatic send_seq(input logic [63:0] v, input int n, input int gap);
    for (int j = 0; j < n; j++) send_byte(v[8*(n-1-j) +: 8], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk) begin
      bus.i_Rx_DV   = 1'b0;
      bus.i_Rx_Byte = 8'($urandom);
    end
  endtask

  task automatic clear_all();
    stim_b.delete();
    stim_e.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic push_exp(input logic [1:0] kind, input int unsigned at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.id   = m_id;
    e.len  = m_len;
    e.pay  = m_pay;
    exp_q.push_back(e);
  endtask

  // First index in (from, upto] whose byte arrives too late (or never arrives).
  function automatic int first_gap(input int from, input int upto);
    for (int k = from + 1; k <= upto; k++) begin
      if (k >= stim_b.size()) return k;
      if (stim_e[k] - stim_e[k-1] > T) return k;
    end
    return -1;
  endfunction

  // Frame-level reference: scans the recorded byte stream for frames.
  task automatic model_run();
    int i, k, n, last;
    logic [7:0] len, sum;
    n = stim_b.size();
    i = 0;
    while (i < n) begin
      if (stim_b[i] != SYNC) begin i++; continue; end
      k = first_gap(i, i + 2);
      if (k >= 0) begin push_exp(K_TO, stim_e[k-1] + T); i = k; continue; end
      len = stim_b[i+2];
      if (int'(len) > MAX) begin push_exp(K_LEN, stim_e[i+2]); i += 3; continue; end
      last = i + 3 + int'(len);
      k = first_gap(i + 2, last);
      if (k >= 0) begin push_exp(K_TO, stim_e[k-1] + T); i = k; continue; end
      sum = 8'(stim_b[i+1] + len);
      for (int p = 0; p < int'(len); p++) sum = 8'(sum + stim_b[i+3+p]);
      if (sum == stim_b[last]) begin
        m_id  = stim_b[i+1];
        m_len = len[4:0];
        m_pay = '0;
        for (int p = 0; p < int'(len); p++) m_pay[8*p +: 8] = stim_b[i+3+p];
        push_exp(K_VALID, stim_e[last]);
      end else begin
        push_exp(K_CHK, stim_e[last]);
      end
      i = last + 1;
    end
  endtask

  task automatic send_random_frame(input int mx);
    logic [7:0] cmd, len, sum, b;
    cmd = 8'($urandom);
    len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(MAX + 1, 255)) : 8'($urandom_range(0, MAX));
    send_byte(SYNC, rgap(mx));
    send_byte(cmd, rgap(mx));
    send_byte(len, rgap(mx));
    if (int'(len) <= MAX) begin
      sum = 8'(cmd + len);
      for (int k = 0; k < int'(len); k++) begin
        b   = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom);
        sum = 8'(sum + b);
        send_byte(b, rgap(mx));
      end
      if ($urandom_range(0, 4) == 0) sum = sum ^ (8'd1 << $urandom_range(0, 7));
      send_byte(sum, rgap(mx));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = SYNC;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.o_Cmd_Valid, bus.o_Chk_Err, bus.o_Len_Err, bus.o_Timeout_Err} !== 4'b0) begin
      bad++; $display("FAIL reset pulses: got %b want 0000",
        {bus.o_Cmd_Valid, bus.o_Chk_Err, bus.o_Len_Err, bus.o_Timeout_Err});
    end
    total++;
    if (bus.o_Cmd_Id !== 8'h00) begin bad++; $display("FAIL reset id: got %h want 00", bus.o_Cmd_Id); end
    total++;
    if (bus.o_Cmd_Len !== 5'd0) begin bad++; $display("FAIL reset len: got %0d want 0", bus.o_Cmd_Len); end
    total++;
    if (bus.o_Cmd_Payload !== '0) begin bad++; $display("FAIL reset payload: got %h want 0", bus.o_Cmd_Payload); end
    bus.i_Rx_DV = 1'b0;
    rst = 1'b0;
    m_id = '0; m_len = '0; m_pay = '0;
    idle(5);
    clear_all();
  endtask

  task automatic test_good_and_chk();
    clear_all();
    send_seq(64'hA5_01_02_10_20_33, 6, 320);
    send_seq(64'hA5_01_02_10_20_34, 6, 320);
    idle(20);
    model_run();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL good_chk count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      ev_t got;
      got = (k < obs_q.size()) ? obs_q[k] : '0;
      total++;
      if (got !== exp_q[k]) begin bad++; $display("FAIL good_chk ev%0d: got %s want %s", k, fmt(got), fmt(exp_q[k])); end
    end
    total++;
    if (bus.o_Cmd_Payload !== 64'h2010) begin
      bad++; $display("FAIL good_chk held payload: got %h want %h", bus.o_Cmd_Payload, 64'h2010);
    end
  endtask

  task automatic test_len_err();
    clear_all();
    send_seq(64'hA5_07_09, 3, 320);
    send_seq(64'hA5_07_00_07, 4, 320);
    idle(20);
    model_run();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL len_err count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      ev_t got;
      got = (k < obs_q.size()) ? obs_q[k] : '0;
      total++;
      if (got !== exp_q[k]) begin bad++; $display("FAIL len_err ev%0d: got %s want %s", k, fmt(got), fmt(exp_q[k])); end
    end
  endtask

  task automatic test_noise();
    clear_all();
    send_seq(64'h00_FF_3C, 3, 320);
    send_seq(64'hA5_02_01_A5_A8, 5, 320);
    idle(20);
    model_run();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL noise count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      ev_t got;
      got = (k < obs_q.size()) ? obs_q[k] : '0;
      total++;
      if (got !== exp_q[k]) begin bad++; $display("FAIL noise ev%0d: got %s want %s", k, fmt(got), fmt(exp_q[k])); end
    end
  endtask

  task automatic test_timeout();
    clear_all();
    send_seq(64'hA5_01_02_10, 4, 320);
    send_byte(8'hA5, T + 100);
    send_seq(64'h01_02_10_20_33, 5, 320);
    send_seq(64'hA5_01_02_10, 4, 320);
    send_byte(8'h20, T);
    send_byte(8'h33, 320);
    send_seq(64'hA5_01_02_10, 4, 320);
    send_byte(8'h20, T + 1);
    send_byte(8'h33, 320);
    send_seq(64'hA5_01_02_10, 4, 320);
    idle(T + 20);
    model_run();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL timeout count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      ev_t got;
      got = (k < obs_q.size()) ? obs_q[k] : '0;
      total++;
      if (got !== exp_q[k]) begin bad++; $display("FAIL timeout ev%0d: got %s want %s", k, fmt(got), fmt(exp_q[k])); end
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    send_seq(64'hA5_03_01_55_59, 5, 320);
    idle(20);
    model_run();
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL reset_mid pre-frame: got %0d events want %s", obs_q.size(), fmt(exp_q[0]));
    end
    clear_all();
    send_seq(64'hA5_01_02_10, 4, 320);
    idle(5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.o_Cmd_Id, bus.o_Cmd_Len, bus.o_Cmd_Payload} !== '0) begin
      bad++; $display("FAIL reset_mid outputs: got id=%h len=%0d pay=%h want all 0",
        bus.o_Cmd_Id, bus.o_Cmd_Len, bus.o_Cmd_Payload);
    end
    rst = 1'b0;
    m_id = '0; m_len = '0; m_pay = '0;
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL reset_mid pulses: got %0d want 0", obs_q.size()); end
    clear_all();
    send_seq(64'hA5_01_02_10_20_33, 6, 320);
    idle(20);
    model_run();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL reset_mid count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      ev_t got;
      got = (k < obs_q.size()) ? obs_q[k] : '0;
      total++;
      if (got !== exp_q[k]) begin bad++; $display("FAIL reset_mid ev%0d: got %s want %s", k, fmt(got), fmt(exp_q[k])); end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    for (int f = 0; f < 8; f++) send_random_frame(1);
    idle(T + 20);
    model_run();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      ev_t got;
      got = (k < obs_q.size()) ? obs_q[k] : '0;
      total++;
      if (got !== exp_q[k]) begin bad++; $display("FAIL b2b ev%0d: got %s want %s", k, fmt(got), fmt(exp_q[k])); end
    end
    total++;
    if ({bus.o_Cmd_Id, bus.o_Cmd_Len, bus.o_Cmd_Payload} !== {m_id, m_len, m_pay}) begin
      bad++; $display("FAIL b2b held word: got id=%h len=%0d pay=%h want id=%h len=%0d pay=%h",
        bus.o_Cmd_Id, bus.o_Cmd_Len, bus.o_Cmd_Payload, m_id, m_len, m_pay);
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int f = 0; f < 30; f++) begin
      int nn;
      nn = int'($urandom_range(0, 2));
      for (int z = 0; z < nn; z++) send_byte(8'($urandom), rgap(4));
      send_random_frame(4);
    end
    idle(T + 20);
    model_run();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      ev_t got;
      got = (k < obs_q.size()) ? obs_q[k] : '0;
      total++;
      if (got !== exp_q[k]) begin bad++; $display("FAIL random ev%0d: got %s want %s", k, fmt(got), fmt(exp_q[k])); end
    end
    total++;
    if (multi !== 0) begin bad++; $display("FAIL exclusive pulses: got %0d overlapping cycles want 0", multi); end
  endtask

  initial begin
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    test_reset();
    test_good_and_chk();
    test_len_err();
    test_noise();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
